// File: rtl/pf_mem_responder.sv
// Memory-side responder for the prefetcher's 16-bit fetch port: fixed wait-state
// latency, then sequential words from an internal RAM loaded through a backdoor port.
module pf_mem_responder #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [ADDR_W-1:0]     adr,
    output logic                  ack,
    output logic [DATA_W-1:0]     dtr,
    input  logic                  stall,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_adr,
    input  logic [DATA_W-1:0]     ld_dat
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_STREAM
    } state_t;

    state_t            state;
    logic              ack_q;
    logic [ADDR_W-1:0] ptr;
    logic [3:0]        cnt;

    logic [DATA_W-1:0] mem [DEPTH];

    // RAM has no reset; a read of the index being written at the same edge sees old data.
    always_ff @(posedge clk) begin
        if (ld_en)
            mem[ld_adr] <= ld_dat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            ack_q <= 1'b0;
            dtr   <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    ack_q <= 1'b0;
                    if (req) begin
                        ptr   <= adr;
                        cnt   <= CNT_INIT;
                        state <= (WAIT_STATES == 0) ? S_STREAM : S_WAIT;
                    end
                end
                S_WAIT: begin
                    ack_q <= 1'b0;
                    if (!req)
                        state <= S_IDLE;
                    else if (cnt == 4'd0)
                        state <= S_STREAM;
                    else
                        cnt <= cnt - 4'd1;
                end
                S_STREAM: begin
                    if (!req) begin
                        ack_q <= 1'b0;
                        state <= S_IDLE;
                    end else if (stall) begin
                        ack_q <= 1'b0;
                    end else begin
                        ack_q <= 1'b1;
                        dtr   <= mem[ptr[DEPTH_LOG2-1:0]];
                        ptr   <= ptr + 1'b1;
                    end
                end
                default: begin
                    ack_q <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Gate with req so a dropped request never sees a word, even mid-burst.
    assign ack = ack_q & req;

endmodule

// File: tb/tb_pf_mem_responder.sv
// Directed bench for pf_mem_responder: inputs change and outputs are sampled on the falling edge.
module tb_pf_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [19:0] adr;
    logic        ack;
    logic [15:0] dtr;
    logic        stall;
    logic        ld_en;
    logic [9:0]  ld_adr;
    logic [15:0] ld_dat;

    int n_cmp = 0;
    int n_err = 0;

    pf_mem_responder #(
        .ADDR_W(20), .DATA_W(16), .DEPTH_LOG2(10), .WAIT_STATES(2)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .adr(adr), .ack(ack), .dtr(dtr),
        .stall(stall), .ld_en(ld_en), .ld_adr(ld_adr), .ld_dat(ld_dat)
    );

    always #5 clk = ~clk;

    task automatic load_word(input logic [9:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_adr = a; ld_dat = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        req = 1'b0; stall = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got=%b want=0", ack); end
        n_cmp++; if (dtr !== 16'h0000) begin n_err++; $display("FAIL reset_dtr got=%h want=0000", dtr); end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid;
        req = 1'b1; adr = 20'hA2C1;
        for (int k = 0; k <= 4; k++) @(negedge clk);
        n_cmp++; if (ack !== 1'b1 || dtr !== 16'h1001) begin n_err++; $display("FAIL rstmid_pre got=%b/%h want=1/1001", ack, dtr); end
        rst = 1'b1;
        #1;
        n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL rstmid_ack got=%b want=0", ack); end
        n_cmp++; if (dtr !== 16'h0000) begin n_err++; $display("FAIL rstmid_dtr got=%h want=0000", dtr); end
        @(negedge clk);
        req = 1'b0; rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL rstidle_ack cyc=%0d got=%b want=0", k, ack); end
        end
    endtask

    task automatic test_basic;
        logic exp_ack;
        req = 1'b1; adr = 20'hA2C1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            exp_ack = (k >= 3);
            n_cmp++; if (ack !== exp_ack) begin n_err++; $display("FAIL basic_ack k=%0d got=%b want=%b", k, ack, exp_ack); end
            if (k >= 3) begin
                n_cmp++; if (dtr !== 16'(16'h1000 + k - 3)) begin n_err++; $display("FAIL basic_dtr k=%0d got=%h want=%h", k, dtr, 16'(16'h1000 + k - 3)); end
            end
        end
        idle_gap(2);
    endtask

    task automatic test_stall;
        logic exp_ack;
        logic [15:0] exp_d;
        req = 1'b1; adr = 20'hA2C1;
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            exp_ack = (k == 3) || (k >= 6);
            exp_d = (k == 3) ? 16'h1000 : 16'(16'h1000 + k - 5);
            n_cmp++; if (ack !== exp_ack) begin n_err++; $display("FAIL stall_ack k=%0d got=%b want=%b", k, ack, exp_ack); end
            if (exp_ack) begin
                n_cmp++; if (dtr !== exp_d) begin n_err++; $display("FAIL stall_dtr k=%0d got=%h want=%h", k, dtr, exp_d); end
            end
            if (k == 3) stall = 1'b1;
            if (k == 5) stall = 1'b0;
        end
        idle_gap(2);
    endtask

    task automatic test_stall_in_wait;
        req = 1'b1; stall = 1'b1; adr = 20'h002C3;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            if (k < 3) begin
                n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL wstall_ack k=%0d got=%b want=0", k, ack); end
            end else begin
                n_cmp++; if (ack !== 1'b1 || dtr !== 16'h1002) begin n_err++; $display("FAIL wstall_first got=%b/%h want=1/1002", ack, dtr); end
            end
            if (k == 2) stall = 1'b0;
        end
        idle_gap(2);
    endtask

    task automatic test_flush;
        logic exp_ack;
        logic [15:0] exp_d;
        req = 1'b1; adr = 20'hA2C1;
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            exp_ack = (k >= 3 && k <= 5) || (k >= 10);
            exp_d = (k <= 5) ? 16'(16'h1000 + k - 3) : 16'(16'h0A10 + k - 10);
            n_cmp++; if (ack !== exp_ack) begin n_err++; $display("FAIL flush_ack k=%0d got=%b want=%b", k, ack, exp_ack); end
            if (exp_ack) begin
                n_cmp++; if (dtr !== exp_d) begin n_err++; $display("FAIL flush_dtr k=%0d got=%h want=%h", k, dtr, exp_d); end
            end
            if (k == 5) begin
                req = 1'b0;
                #1;
                n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL flush_kill got=%b want=0", ack); end
            end
            if (k == 6) begin req = 1'b1; adr = 20'h00010; end
        end
        idle_gap(2);
    endtask

    task automatic test_wrap;
        req = 1'b1; adr = 20'hFFFFF;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k == 3) begin
                n_cmp++; if (ack !== 1'b1 || dtr !== 16'hBEEF) begin n_err++; $display("FAIL wrap_w0 got=%b/%h want=1/beef", ack, dtr); end
                n_cmp++; if (dut.ptr !== 20'h00000) begin n_err++; $display("FAIL wrap_ptr got=%h want=00000", dut.ptr); end
            end
            if (k == 4) begin
                n_cmp++; if (ack !== 1'b1 || dtr !== 16'hCAFE) begin n_err++; $display("FAIL wrap_w1 got=%b/%h want=1/cafe", ack, dtr); end
            end
        end
        idle_gap(2);
    endtask

    task automatic test_collision;
        req = 1'b1; adr = 20'h00020;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k == 3) begin
                n_cmp++; if (ack !== 1'b1 || dtr !== 16'h2020) begin n_err++; $display("FAIL coll_w0 got=%b/%h want=1/2020", ack, dtr); end
                ld_en = 1'b1; ld_adr = 10'h021; ld_dat = 16'h5555;
            end
            if (k == 4) begin
                ld_en = 1'b0;
                n_cmp++; if (ack !== 1'b1 || dtr !== 16'h2021) begin n_err++; $display("FAIL coll_old got=%b/%h want=1/2021", ack, dtr); end
            end
            if (k == 5) begin
                n_cmp++; if (ack !== 1'b1 || dtr !== 16'h2022) begin n_err++; $display("FAIL coll_w2 got=%b/%h want=1/2022", ack, dtr); end
            end
        end
        idle_gap(2);
        req = 1'b1; adr = 20'h00021;
        for (int k = 0; k <= 3; k++) @(negedge clk);
        n_cmp++; if (ack !== 1'b1 || dtr !== 16'h5555) begin n_err++; $display("FAIL coll_new got=%b/%h want=1/5555", ack, dtr); end
        idle_gap(2);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; adr = '0; stall = 1'b0;
        ld_en = 1'b0; ld_adr = '0; ld_dat = '0;
        repeat (2) @(negedge clk);
        test_reset;
        for (int i = 0; i < 8; i++) load_word(10'(10'h2C1 + i), 16'(16'h1000 + i));
        load_word(10'h010, 16'h0A10);
        load_word(10'h011, 16'h0A11);
        load_word(10'h3FF, 16'hBEEF);
        load_word(10'h000, 16'hCAFE);
        for (int i = 0; i < 3; i++) load_word(10'(10'h020 + i), 16'(16'h2020 + i));
        test_reset_mid;
        test_basic;
        test_stall;
        test_stall_in_wait;
        test_flush;
        test_wrap;
        test_collision;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pf_mem_responder.md
Name: pf_mem_responder

Overview:
- Bus responder (memory side) for the instruction prefetcher's 16-bit fetch port.
- Accepts a level request `req` with a 20-bit word address `adr`, applies WAIT_STATES latency, then streams sequential 16-bit words on `dtr`, qualified by `ack`.
- Backs the stream with an internal word RAM, loaded through a backdoor port. `stall` injects ack gaps.
- Serves as the simulation and FPGA memory model behind the prefetcher.

Parameters:
- ADDR_W, 20, word address width of `adr`.
- DATA_W, 16, word width of `dtr`.
- DEPTH_LOG2, 10, log2 of RAM depth in words; RAM index = adr[DEPTH_LOG2-1:0].
- WAIT_STATES, 2, idle cycles between accepting a request and the first data cycle (0..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  1  fetch request, level; held high for the whole burst.
- adr  in  ADDR_W  start word address; sampled only when leaving IDLE.
- ack  out  1  data valid; one word is transferred per clk cycle with ack=1.
- dtr  out  DATA_W  read data; valid only while ack=1.
- stall  in  1  when high at an edge in STREAM, no word is produced next cycle.
- ld_en  in  1  backdoor RAM write enable.
- ld_adr  in  DEPTH_LOG2  backdoor write index.
- ld_dat  in  DATA_W  backdoor write data.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, ack_q=0, dtr=0, ptr=0, cnt=0.
  - RAM contents are not cleared.
  - Reset asserted mid-burst drops ack immediately (ack_q is cleared asynchronously).
- Output gating: ack = ack_q & req (combinational gate). No word is ever presented while req=0.
- States IDLE, WAIT, STREAM.
- IDLE:
  - ack_q<=0.
  - If req=1: ptr<=adr, cnt<=WAIT_STATES-1, next=WAIT. If WAIT_STATES=0, next=STREAM.
- WAIT:
  - ack_q<=0.
  - If req=0: next=IDLE (request abandoned).
  - Else if cnt=0: next=STREAM.
  - Else cnt<=cnt-1.
- STREAM, each edge:
  - req=0: ack_q<=0, next=IDLE.
  - req=1, stall=1: ack_q<=0, ptr held, dtr held.
  - req=1, stall=0: ack_q<=1, dtr<=RAM[ptr[DEPTH_LOG2-1:0]], ptr<=ptr+1.
- Latency: with req sampled high in IDLE at edge E0, the first ack=1 cycle begins at edge E0+WAIT_STATES+1 and carries RAM[adr].
- Word k of a burst (no stalls) appears at edge E0+WAIT_STATES+1+k and carries RAM[adr+k].
- Redirect/flush: the initiator drops req for at least one edge. The next req in IDLE re-samples adr and pays the full WAIT_STATES again.
- A req drop in STREAM kills ack in the same cycle (gating). The word in flight is discarded, and ptr is irrelevant after return to IDLE.
- Arithmetic:
  - ptr is ADDR_W bits and wraps 2^ADDR_W-1 -> 0.
  - The RAM index aliases modulo 2^DEPTH_LOG2, e.g. adr 0x003FF then 0x00400 reads index 0x3FF then 0x000 (DEPTH_LOG2=10).
- Backdoor:
  - ld_en=1 writes RAM[ld_adr]<=ld_dat at the edge, in any state including reset-deasserted IDLE.
  - A simultaneous read of the same index at that edge returns the old data (read-before-write).
- stall during IDLE or WAIT has no effect; the WAIT count is not extended.
- dtr holds its last value whenever ack_q=0; the bench must not check dtr then.

Test Plan:
- Reset/idle: rst=1 mid-stream with req=1 -> ack=0 and dtr=0 immediately; after release with req=0, ack stays 0 for 10 cycles.
- Basic burst: preload RAM[0x2C1..0x2C8]=0x1000+i, WAIT_STATES=2, adr=0xA2C1, req=1 at E0 -> ack first high at E0+3, then 8 consecutive ack cycles carrying 0x1000..0x1007.
- Stall gaps: same burst with stall=1 at edges E0+4 and E0+5 -> ack low for 2 cycles, no skipped or duplicated word, sequence still 0x1000..0x1007 contiguous in ack cycles.
- Flush/redirect: req drops for 1 cycle after the 3rd word, new adr=0x00010 -> ack falls in the same cycle, next ack at 3 cycles after re-sample carrying RAM[0x010].
- Wrap: adr=0xFFFFF, preload RAM[0x3FF]=0xBEEF, RAM[0x000]=0xCAFE -> words 0xBEEF then 0xCAFE, ptr=0x00000.
- Backdoor collision: during streaming, ld_en writes 0x5555 to the index being read at that edge -> that ack cycle shows the old value; a re-fetch of the same address returns 0x5555.
